display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//  Upstream feeder for the single-digit seven-segment decoder. Converts a binary
//  amount (vending credit, change, price) to BCD with a sequential shift-add-3
//  converter, then time-multiplexes the digits onto one 4-bit printnumber bus
//  with a one-hot digit enable. The decoder consumes printnumber; digit_enable
//  drives the display digit commons.
// PARAMETERS
//  NUM_DIGITS   4      digits on the display (1..8)
//  BIN_W        14     width of the binary input value
//  REFRESH_DIV  50000  clock cycles per digit slot (>=2)
// PORTS
//  clock          in   1           system clock, all logic on rising edge
//  reset          in   1           asynchronous, active-high reset
//  value          in   BIN_W       binary amount to display
//  load           in   1           1-cycle request to convert and show value
//  blank_leading  in   1           1 = suppress leading zeros
//  busy           out  1           conversion in progress; load ignored
//  overflow       out  1           last loaded value exceeded 10^NUM_DIGITS-1
//  printnumber    out  4           BCD/code of current digit, to decoder
//  digit_enable   out  NUM_DIGITS  one-hot active-high enable, bit0 = LS digit
// BEHAVIOUR
//  Reset (async, active-high): busy=0, overflow=0, printnumber=0, digit_enable=0,
//   shown register = all zero digits, digit index=0, prescaler=0, FSM=IDLE.
//  FSM states: IDLE, CONVERT, COMMIT.
//   IDLE: load=1 -> capture value, clear shifter, bit count=BIN_W, go CONVERT.
//   CONVERT: one input bit per cycle: add 3 to every BCD nibble >=5, then shift
//    left inserting the next MSB. After BIN_W cycles go COMMIT.
//   COMMIT: if captured value > 10^NUM_DIGITS-1, shown register = every digit
//    4'hE and overflow=1; else shown register = BCD result, overflow=0. Go IDLE.
//  busy=1 in CONVERT and COMMIT: exactly BIN_W+1 cycles, starting the cycle
//   after load is sampled. load while busy is dropped, not queued.
//  Shown register updates atomically in COMMIT only; scanning never displays a
//   partially converted value. Display stays valid during conversion.
//  Scan: prescaler counts 0..REFRESH_DIV-1; at terminal count the digit index
//   advances, wrapping NUM_DIGITS-1 -> 0. printnumber = shown digit[index],
//   registered.
//  Blanking: if blank_leading=1, a digit is blank when it and all more
//   significant digits are 0. Digit 0 is never blank. Overflow pattern is never
//   blanked. A blank slot drives digit_enable=0 for the whole slot.
//  Alignment: the downstream decoder registers its output, adding one cycle;
//   digit_enable is therefore delayed one cycle relative to printnumber, so
//   segments and enable change on the same edge.
//  Slot change and COMMIT in the same cycle: the new index reads the new shown
//   register.
//  Reset mid-conversion aborts; the previous value is lost and the display
//   shows zero after reset.
//  Value width: the BCD shifter is 4*NUM_DIGITS+BIN_W bits. Overflow compare
//   uses the full BIN_W-bit captured value.
// STRUCTURE
//  Package display_pkg: DIGIT_W=4, CODE_ERR=4'hE, CODE_ZERO=4'h0, and the FSM
//   state enum (S_IDLE, S_CONVERT, S_COMMIT).
//  Sub-module bin2bcd_seq (start/busy/done, parameterised BIN_W, NUM_DIGITS).
//   It holds the FSM and shifter. The top level holds the shown register,
//   prescaler, scan index, blanking and output alignment.
// TESTING  (REFRESH_DIV=4, NUM_DIGITS=4, BIN_W=14)
//  Reset asserted mid-scan -> all outputs 0 immediately. After release, digit 0
//   is shown with printnumber=0 and enable 4'b0001 one cycle later.
//  load value=1234 -> busy high 15 cycles. Then scan yields 4,3,2,1 with
//   enables 0001,0010,0100,1000, each held 4 cycles, enable lagging by 1 cycle.
//  load 10000 -> overflow=1, every slot printnumber=4'hE. Then load 5 ->
//   overflow=0.
//  blank_leading=1, value=7 -> slots 1..3 have enable=0. Slot 0 shows 7.
//   value=0 -> slot 0 still shows 0.
//  load 42, then load 99 on the 3rd busy cycle -> 99 is ignored and the display
//   shows 0042. During conversion, 1234 remains displayed unchanged.
//  load 9999 and 0 -> exact BCD 9999 and 0000 (boundary values).

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the scanned BCD display driver.
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] CODE_ERR  = 4'hE;
    localparam logic [DIGIT_W-1:0] CODE_ZERO = 4'h0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              value,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]              captured
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t           state;
    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  adj;
    logic [CNT_W-1:0] cnt;

    // Digits sit above the binary field; correct each before the shift.
    always_comb begin
        adj = sh;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sh[BIN_W+DIGIT_W*i +: DIGIT_W] >= 4'd5)
                adj[BIN_W+DIGIT_W*i +: DIGIT_W] =
                    sh[BIN_W+DIGIT_W*i +: DIGIT_W] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sh       <= '0;
            cnt      <= '0;
            captured <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        captured <= value;
                        sh       <= {{BCD_W{1'b0}}, value};
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    sh  <= {adj[SH_W-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd = sh[SH_W-1 -: BCD_W];

endmodule

// File: rtl/display_scan_driver.sv
// Converts a binary amount to BCD and time-multiplexes the digits onto
// printnumber with a one-cycle-lagged one-hot digit enable.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic                  blank_leading,
    output logic                  busy,
    output logic                  overflow,
    output logic [DIGIT_W-1:0]    printnumber,
    output logic [NUM_DIGITS-1:0] digit_enable
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

    logic                  done;
    logic [BCD_W-1:0]      bcd;
    logic [BIN_W-1:0]      captured;
    logic [BCD_W-1:0]      shown;
    logic [BCD_W-1:0]      shown_d;
    logic                  ovf_d;
    logic [PS_W-1:0]       presc;
    logic                  tc;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_d;
    logic [NUM_DIGITS-1:0] en_d;
    logic [NUM_DIGITS-1:0] en_stage;
    logic [DIGIT_W-1:0]    pn_d;
    logic                  lead_zero;

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clock    (clock),
        .reset    (reset),
        .start    (load),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .captured (captured)
    );

    always_comb begin
        shown_d = shown;
        ovf_d   = overflow;
        if (done) begin
            if (64'(captured) > MAX_VAL) begin
                shown_d = {NUM_DIGITS{CODE_ERR}};
                ovf_d   = 1'b1;
            end else begin
                shown_d = bcd;
                ovf_d   = 1'b0;
            end
        end
    end

    assign tc = (presc == PS_W'(REFRESH_DIV - 1));

    always_comb begin
        idx_d = idx;
        if (tc)
            idx_d = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    // Next-state index and shown value feed the output so a slot change
    // coinciding with a commit already shows the new amount.
    always_comb begin
        lead_zero = 1'b1;
        en_d      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero &&
                        (shown_d[DIGIT_W*i +: DIGIT_W] == CODE_ZERO);
            if (idx_d == IDX_W'(i))
                en_d[i] = !(blank_leading && !ovf_d && lead_zero && i != 0);
        end
    end

    assign pn_d = shown_d[DIGIT_W*idx_d +: DIGIT_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            idx          <= '0;
            shown        <= '0;
            overflow     <= 1'b0;
            printnumber  <= '0;
            en_stage     <= '0;
            digit_enable <= '0;
        end else begin
            presc        <= tc ? '0 : presc + 1'b1;
            idx          <= idx_d;
            shown        <= shown_d;
            overflow     <= ovf_d;
            printnumber  <= pn_d;
            en_stage     <= en_d;
            digit_enable <= en_stage;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Table, hand-sequence and randomized checks of display_scan_driver
// against a cycle-count reference model of the scanned display.
module tb_display_scan_driver;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;
    localparam int CONV_CYCLES = BW + 1;

    logic          clock;
    logic          reset;
    logic [BW-1:0] value;
    logic          load;
    logic          blank_leading;
    logic          busy;
    logic          overflow;
    logic [3:0]    printnumber;
    logic [ND-1:0] digit_enable;

    display_scan_driver #(
        .NUM_DIGITS  (ND),
        .BIN_W       (BW),
        .REFRESH_DIV (RD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .value         (value),
        .load          (load),
        .blank_leading (blank_leading),
        .busy          (busy),
        .overflow      (overflow),
        .printnumber   (printnumber),
        .digit_enable  (digit_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: displayed digits, conversion countdown, edge count.
    int md[ND];
    int mov;
    int mcnt;
    int mpend;
    int k;
    int en_prev;
    int exp_en;

    typedef struct {
        int v;
        bit blank;
        int ovf;
        int d[ND];
        bit [ND-1:0] mask;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int v, input bit b, input int o,
                                input int d0, input int d1, input int d2,
                                input int d3, input bit [ND-1:0] m);
        vec_t r;
        r.v = v; r.blank = b; r.ovf = o;
        r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
        r.mask = m;
        return r;
    endfunction

    function automatic int slot_of(input int edges);
        return (edges / RD) % ND;
    endfunction

    task automatic model_commit(input int v);
        int p;
        p = 1;
        if (v > 9999) begin
            mov = 1;
            for (int i = 0; i < ND; i++) md[i] = 14;
        end else begin
            mov = 0;
            for (int i = 0; i < ND; i++) begin
                md[i] = (v / p) % 10;
                p = p * 10;
            end
        end
    endtask

    function automatic int model_enable(input int s, input bit b);
        bit z;
        z = 1'b1;
        for (int j = s; j < ND; j++) if (md[j] != 0) z = 1'b0;
        if (b && mov == 0 && s != 0 && z) return 0;
        return 1 << s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) md[i] = 0;
        mov = 0; mcnt = 0; mpend = 0; k = 0; en_prev = 0; exp_en = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (!reset) begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) model_commit(mpend);
            end else if (load) begin
                mcnt  = CONV_CYCLES;
                mpend = int'(value);
            end
            k++;
            exp_en  = en_prev;
            en_prev = model_enable(slot_of(k), blank_leading);
            chk("busy", int'(busy), (mcnt > 0) ? 1 : 0);
            chk("overflow", int'(overflow), mov);
            chk("printnumber", int'(printnumber), md[slot_of(k)]);
            chk("digit_enable", int'(digit_enable), exp_en);
        end
    endtask

    task automatic pulse_load(input int v);
        value = BW'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int busy_seen);
        int n;
        n = 0;
        busy_seen = busy ? 1 : 0;
        while (busy && n < 40) begin
            step();
            if (busy) busy_seen++;
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic scan_check(input string name, input vec_t r);
        int obs_pn[ND];
        int obs_en[ND];
        for (int i = 0; i < ND; i++) begin
            obs_pn[i] = -1;
            obs_en[i] = -1;
        end
        repeat (2 * RD * ND + 1) begin
            step();
            obs_pn[slot_of(k)] = int'(printnumber);
            if (k >= 1) obs_en[slot_of(k - 1)] = int'(digit_enable);
        end
        chk({name, "_ovf"}, int'(overflow), r.ovf);
        for (int s = 0; s < ND; s++) begin
            chk({name, "_pn"}, obs_pn[s], r.d[s]);
            chk({name, "_en"}, obs_en[s], r.mask[s] ? (1 << s) : 0);
        end
    endtask

    task automatic hold_reset_check();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_pn", int'(printnumber), 0);
        chk("rst_en", int'(digit_enable), 0);
        @(posedge clock);
        #1;
        chk("rst_hold_en", int'(digit_enable), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int bc;
        int v;
        vec_t r;

        reset = 1'b1;
        value = '0;
        load = 1'b0;
        blank_leading = 1'b0;
        model_reset();
        #12;
        hold_reset_check();

        step();
        chk("post_rst_pn", int'(printnumber), 0);
        chk("post_rst_en0", int'(digit_enable), 0);
        step();
        chk("post_rst_en1", int'(digit_enable), 1);

        tbl[0] = mk(1234,  0, 0, 4, 3, 2, 1, 4'b1111);
        tbl[1] = mk(10000, 0, 1, 14, 14, 14, 14, 4'b1111);
        tbl[2] = mk(5,     0, 0, 5, 0, 0, 0, 4'b1111);
        tbl[3] = mk(7,     1, 0, 7, 0, 0, 0, 4'b0001);
        tbl[4] = mk(0,     1, 0, 0, 0, 0, 0, 4'b0001);
        tbl[5] = mk(9999,  0, 0, 9, 9, 9, 9, 4'b1111);
        tbl[6] = mk(0,     0, 0, 0, 0, 0, 0, 4'b1111);
        tbl[7] = mk(42,    1, 0, 2, 4, 0, 0, 4'b0011);
        tbl[8] = mk(16383, 1, 1, 14, 14, 14, 14, 4'b1111);
        tbl[9] = mk(305,   1, 0, 5, 0, 3, 0, 4'b0111);

        for (int i = 0; i < 10; i++) begin
            blank_leading = tbl[i].blank;
            pulse_load(tbl[i].v);
            wait_idle(bc);
            chk("busy_len", bc, CONV_CYCLES);
            scan_check("tbl", tbl[i]);
        end

        // Load while busy is dropped; old value stays on display meanwhile.
        blank_leading = 1'b0;
        pulse_load(1234);
        wait_idle(bc);
        pulse_load(42);
        step();
        step();
        chk("third_busy", int'(busy), 1);
        pulse_load(99);
        wait_idle(bc);
        r = mk(42, 0, 0, 2, 4, 0, 0, 4'b1111);
        scan_check("drop", r);

        // Reset in the middle of a conversion.
        pulse_load(5678);
        repeat (5) step();
        hold_reset_check();
        step();
        step();
        chk("abort_en", int'(digit_enable), 1);
        chk("abort_pn", int'(printnumber), 0);
        r = mk(0, 0, 0, 0, 0, 0, 0, 4'b1111);
        scan_check("abort", r);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: v = 9999;
                1: v = 10000;
                2: v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 16383);
            endcase
            blank_leading = 1'($urandom_range(0, 1));
            pulse_load(v);
            repeat ($urandom_range(0, 30)) step();
        end
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
